memshare_skid_ctrl_mc: RTL and testbench

- Multi-channel, parametrised successor of the SCU.memShare() skid-buffer selector.
- Generates one skid-mux select per shared-memory channel from each channel's RFMU isGtr stream.
- Generates the pipeline-cycle boundary internally from a cycle counter, not from an input.
- Adds a per-channel hold-off state machine that suppresses skid for a programmable time after a back-to-back isGtr run (DRC2). Sits between RFMU and the SCU skid multiplexers.

---
 rtl/memShare_config_pkg.sv | 19 +
 rtl/memshare_skid_ch.sv | 104 ++++++++++
 rtl/memshare_skid_ctrl_mc.sv | 112 +++++++++++
 tb/tb_memshare_skid_ctrl_mc.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/memShare_config_pkg.sv
// Shared configuration for the memShare skid-select controller.
// Holds the default isGtr history depth, the skid-select encodings and the
// per-channel hold-off FSM state type.
package memShare_config_pkg;

    // Default isGtr history depth; a back-to-back run is this plus one.
    localparam int unsigned MAX_ALLOC_SEQ_NUM_DEF = 3;

    // Skid multiplexer select encodings.
    localparam logic NOSKID = 1'b0;
    localparam logic SKID   = 1'b1;

    typedef enum logic [1:0] {
        SKID_IDLE,
        SKID_TRACK,
        SKID_HOLDOFF
    } skid_state_e;

endpackage

// File: rtl/memshare_skid_ch.sv
// One memShare channel: isGtr history, back-to-back detector, hold-off FSM
// with its counter, and the combinational skid select for this channel.
// Ports:
//   sys_clk_i    system clock
//   rst_i        synchronous reset, active-high
//   busy_i       SCU.memShare() operation in progress
//   pipe_begin_i first cycle of a pipeline cycle (shared)
//   is_gtr_i     isGtr sample from RFMU for this channel
//   skid_net_o   combinational skid select (SKID/NOSKID)
//   holdoff_o    channel is in HOLDOFF (registered state decode)
module memshare_skid_ch
    import memShare_config_pkg::*;
#(
    parameter int unsigned MAX_ALLOC_SEQ_NUM = MAX_ALLOC_SEQ_NUM_DEF,
    parameter int unsigned HOLDOFF_CYC       = 2
) (
    input  logic sys_clk_i,
    input  logic rst_i,
    input  logic busy_i,
    input  logic pipe_begin_i,
    input  logic is_gtr_i,
    output logic skid_net_o,
    output logic holdoff_o
);

    localparam int unsigned HO_W = (HOLDOFF_CYC > 1) ? $clog2(HOLDOFF_CYC) : 1;
    localparam logic [HO_W-1:0] HO_LOAD = HO_W'(HOLDOFF_CYC - 1);

    logic [MAX_ALLOC_SEQ_NUM-1:0] hist_q, hist_d;
    logic [MAX_ALLOC_SEQ_NUM:0]   win;
    logic                         b2b;
    skid_state_e                  state_q, state_d;
    logic [HO_W-1:0]              ho_cnt_q, ho_cnt_d;
    logic                         holdoff_q;

    // Current sample plus the prior history; all ones marks a back-to-back run.
    assign win = {hist_q, is_gtr_i};
    assign b2b = &win;

    // History only lives for the duration of one operation.
    always_comb begin
        hist_d = '0;
        if (busy_i) begin
            hist_d = win[MAX_ALLOC_SEQ_NUM-1:0];
        end
    end

    // Hold-off FSM next state; busy low overrides every other transition.
    always_comb begin
        state_d  = state_q;
        ho_cnt_d = ho_cnt_q;
        case (state_q)
            SKID_IDLE: begin
                if (busy_i) begin
                    state_d = SKID_TRACK;
                end
            end
            SKID_TRACK: begin
                if (b2b) begin
                    state_d  = SKID_HOLDOFF;
                    ho_cnt_d = HO_LOAD;
                end
            end
            SKID_HOLDOFF: begin
                if (b2b) begin
                    ho_cnt_d = HO_LOAD;
                end else if (ho_cnt_q == '0) begin
                    state_d = SKID_TRACK;
                end else begin
                    ho_cnt_d = ho_cnt_q - HO_W'(1);
                end
            end
            default: begin
                state_d = SKID_IDLE;
            end
        endcase
        if (!busy_i) begin
            state_d  = SKID_IDLE;
            ho_cnt_d = '0;
        end
    end

    // State, counter, history and hold-off flag registers.
    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            state_q   <= SKID_IDLE;
            ho_cnt_q  <= '0;
            hist_q    <= '0;
            holdoff_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ho_cnt_q  <= ho_cnt_d;
            hist_q    <= hist_d;
            holdoff_q <= (state_d == SKID_HOLDOFF);
        end
    end

    assign holdoff_o = holdoff_q;

    // Skid on isGtr, except on a back-to-back run or a pipeline boundary.
    assign skid_net_o = ((state_q == SKID_TRACK) && busy_i && is_gtr_i &&
                         !b2b && !pipe_begin_i) ? SKID : NOSKID;

endmodule

// File: rtl/memshare_skid_ctrl_mc.sv
// Multi-channel memShare skid-select controller. Derives the pipeline-cycle
// boundary from an internal counter, runs one hold-off channel per shared
// memory channel and counts skid-asserted channel-cycles.
// Optional build macro MEMSHARE_SKID_REG_OUT_EN registers isColAddr_skid_o
// (1-cycle latency); otherwise the skid select is combinational.
// Ports:
//   sys_clk              system clock
//   rst                  synchronous reset, active-high
//   scu_memShare_busy_i  high throughout the SCU.memShare() operation
//   isGtr_i              per-channel isGtr from RFMU
//   isColAddr_skid_o     per-channel skid select (1 = SKID)
//   pipeCycle_begin_o    first cycle of each pipeline cycle
//   holdoff_o            per-channel HOLDOFF indication
//   skid_evt_cnt_o       saturating count of skid-asserted channel-cycles
module memshare_skid_ctrl_mc
    import memShare_config_pkg::*;
#(
    parameter int unsigned CH_NUM            = 4,
    parameter int unsigned MAX_ALLOC_SEQ_NUM = MAX_ALLOC_SEQ_NUM_DEF,
    parameter int unsigned PIPE_CYC_LEN      = 4,
    parameter int unsigned HOLDOFF_CYC       = 2,
    parameter int unsigned CNT_W             = 8
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              scu_memShare_busy_i,
    input  logic [CH_NUM-1:0] isGtr_i,
    output logic [CH_NUM-1:0] isColAddr_skid_o,
    output logic              pipeCycle_begin_o,
    output logic [CH_NUM-1:0] holdoff_o,
    output logic [CNT_W-1:0]  skid_evt_cnt_o
);

    localparam int unsigned PC_W  = $clog2(PIPE_CYC_LEN);
    localparam int unsigned POP_W = $clog2(CH_NUM + 1);
    localparam int unsigned SUM_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;
    localparam logic [PC_W-1:0]  PC_LAST = PC_W'(PIPE_CYC_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [PC_W-1:0]   pc_q, pc_d;
    logic [CH_NUM-1:0] skid_net;
    logic [POP_W-1:0]  pop;
    logic [SUM_W-1:0]  sum;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Pipeline-cycle counter: parked at 0 while idle so the first busy cycle is a boundary.
    always_comb begin
        pc_d = '0;
        if (scu_memShare_busy_i) begin
            pc_d = (pc_q == PC_LAST) ? '0 : pc_q + PC_W'(1);
        end
    end

    assign pipeCycle_begin_o = scu_memShare_busy_i && (pc_q == '0);

    // Independent per-channel skid logic.
    for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
        memshare_skid_ch #(
            .MAX_ALLOC_SEQ_NUM (MAX_ALLOC_SEQ_NUM),
            .HOLDOFF_CYC       (HOLDOFF_CYC)
        ) u_ch (
            .sys_clk_i    (sys_clk),
            .rst_i        (rst),
            .busy_i       (scu_memShare_busy_i),
            .pipe_begin_i (pipeCycle_begin_o),
            .is_gtr_i     (isGtr_i[c]),
            .skid_net_o   (skid_net[c]),
            .holdoff_o    (holdoff_o[c])
        );
    end

`ifdef MEMSHARE_SKID_REG_OUT_EN
    logic [CH_NUM-1:0] skid_q;

    // Registered skid select.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            skid_q <= '0;
        end else begin
            skid_q <= skid_net;
        end
    end

    assign isColAddr_skid_o = skid_q;
`else
    assign isColAddr_skid_o = skid_net;
`endif

    // Saturating accumulation of the skid selects actually presented.
    always_comb begin
        pop = '0;
        for (int unsigned i = 0; i < CH_NUM; i++) begin
            pop = pop + POP_W'(isColAddr_skid_o[i]);
        end
        sum   = SUM_W'(cnt_q) + SUM_W'(pop);
        cnt_d = (sum > SUM_W'(CNT_MAX)) ? CNT_MAX : CNT_W'(sum);
    end

    // Shared counter registers.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            pc_q  <= '0;
            cnt_q <= '0;
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
        end
    end

    assign skid_evt_cnt_o = cnt_q;

endmodule

// File: tb/tb_memshare_skid_ctrl_mc.sv
// Self-checking bench for memshare_skid_ctrl_mc: directed scenarios followed
// by randomized traffic, compared every cycle against a behavioural model
// built from run lengths, operation age and hold-off windows.
module tb_memshare_skid_ctrl_mc;

    localparam int CH  = 4;
    localparam int M   = 3;
    localparam int LEN = 4;
    localparam int HC  = 2;
    localparam int CW  = 8;
    localparam int CNT_SAT = (1 << CW) - 1;

    logic          sys_clk = 1'b0;
    logic          rst;
    logic          busy;
    logic [CH-1:0] gtr;
    logic [CH-1:0] skid_o;
    logic          pb_o;
    logic [CH-1:0] ho_o;
    logic [CW-1:0] cnt_o;

    memshare_skid_ctrl_mc #(
        .CH_NUM            (CH),
        .MAX_ALLOC_SEQ_NUM (M),
        .PIPE_CYC_LEN      (LEN),
        .HOLDOFF_CYC       (HC),
        .CNT_W             (CW)
    ) dut (
        .sys_clk             (sys_clk),
        .rst                 (rst),
        .scu_memShare_busy_i (busy),
        .isGtr_i             (gtr),
        .isColAddr_skid_o    (skid_o),
        .pipeCycle_begin_o   (pb_o),
        .holdoff_o           (ho_o),
        .skid_evt_cnt_o      (cnt_o)
    );

    always #5 sys_clk = ~sys_clk;

    // Reference model state
    int            cyc;
    int            op_pos;          // busy cycles already elapsed in the current operation
    int            run_m[CH];       // consecutive isGtr ones seen earlier in this operation
    int            last_fire[CH];   // cycle of the latest back-to-back hit in this operation
    int            cnt_m;
    logic [CH-1:0] skid_reg_m;

    int vectors;
    int miscompares;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_clear_op();
        op_pos = 0;
        for (int c = 0; c < CH; c++) begin
            run_m[c]     = 0;
            last_fire[c] = -1000;
        end
    endtask

    // One clock cycle: drive, check against the model, advance the model.
    task automatic step(input logic b, input logic [CH-1:0] g, input logic r);
        logic          boundary;
        logic          active;
        logic [CH-1:0] b2b;
        logic [CH-1:0] ho_exp;
        logic [CH-1:0] skid_n;
        logic [CH-1:0] skid_exp;
        int            d;

        @(negedge sys_clk);
        busy = b;
        gtr  = g;
        rst  = r;
        #1;

        boundary = b && ((op_pos % LEN) == 0);
        active   = (op_pos > 0);
        for (int c = 0; c < CH; c++) begin
            d         = cyc - last_fire[c];
            b2b[c]    = b && g[c] && (run_m[c] >= M);
            ho_exp[c] = active && (d >= 1) && (d <= HC);
            skid_n[c] = b && active && !ho_exp[c] && g[c] && !b2b[c] && !boundary;
        end
`ifdef MEMSHARE_SKID_REG_OUT_EN
        skid_exp = skid_reg_m;
`else
        skid_exp = skid_n;
`endif

        chk("pipe_begin", 32'(pb_o), 32'(boundary));
        chk("skid", 32'(skid_o), 32'(skid_exp));
        chk("holdoff", 32'(ho_o), 32'(ho_exp));
        chk("evt_cnt", 32'(cnt_o), 32'(cnt_m));

        @(posedge sys_clk);
        if (r) begin
            model_clear_op();
            cnt_m      = 0;
            skid_reg_m = '0;
        end else begin
            cnt_m = cnt_m + $countones(skid_exp);
            if (cnt_m > CNT_SAT) cnt_m = CNT_SAT;
            skid_reg_m = skid_n;
            if (b) begin
                for (int c = 0; c < CH; c++) begin
                    if (active && b2b[c]) last_fire[c] = cyc;
                    run_m[c] = g[c] ? run_m[c] + 1 : 0;
                end
                op_pos++;
            end else begin
                model_clear_op();
            end
        end
        cyc++;
    endtask

    initial begin
        logic [CH-1:0] g;
        logic          b;
        logic          r;

        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        cnt_m       = 0;
        skid_reg_m  = '0;
        model_clear_op();

        rst  = 1'b1;
        busy = 1'b0;
        gtr  = '0;
        repeat (2) @(posedge sys_clk);

        // Idle with isGtr all high: nothing may assert.
        for (int i = 0; i < 10; i++) step(1'b0, 4'hF, 1'b0);

        // Single isGtr, a back-to-back run into hold-off, and a boundary-only isGtr.
        for (int k = 0; k < 12; k++) begin
            g    = '0;
            g[0] = (k == 1);
            g[1] = (k >= 1) && (k <= 6);
            g[2] = (k == 4);
            step(1'b1, g, 1'b0);
        end
        step(1'b0, '0, 1'b0);

        // Busy drops mid hold-off and returns one cycle later.
        for (int k = 0; k < 7; k++) begin
            g    = '0;
            g[1] = (k >= 1);
            step(1'b1, g, 1'b0);
        end
        step(1'b0, 4'b0010, 1'b0);
        for (int k = 0; k < 4; k++) step(1'b1, 4'b0010, 1'b0);

        // Reset in the middle of an operation.
        for (int k = 0; k < 6; k++) step(1'b1, 4'(k * 5 + 3), 1'b0);
        step(1'b1, 4'hA, 1'b1);
        for (int k = 0; k < 6; k++) step(1'b1, 4'h5, 1'b0);
        step(1'b0, '0, 1'b0);

        // Random traffic long enough to saturate the event counter.
        for (int i = 0; i < 1500; i++) begin
            b = ($urandom_range(15) != 0);
            for (int c = 0; c < CH; c++) g[c] = ($urandom_range(3) != 0);
            step(b, g, 1'b0);
        end

        // Random traffic with occasional resets.
        for (int i = 0; i < 800; i++) begin
            b = ($urandom_range(7) != 0);
            g = CH'($urandom);
            r = ($urandom_range(63) == 0);
            step(b, g, r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
